// File: rtl/nios2_dbg_pkg.sv
// Shared constants and helpers for the Nios II JTAG debug sysclk bridge.
package nios2_dbg_pkg;

    localparam int unsigned IR_OCIMEM    = 0;
    localparam int unsigned IR_TRACEMEM  = 1;
    localparam int unsigned IR_BREAK     = 2;
    localparam int unsigned IR_TRACECTRL = 3;

    localparam int unsigned DEFAULT_ACT_BIT = 34;

    function automatic int unsigned n_ch(input int unsigned ir_w);
        return 32'd1 << ir_w;
    endfunction

endpackage

// File: rtl/nios2_dbg_sync_edge.sv
// Synchroniser for a TCK-domain level plus an armed rising-edge detector.
module nios2_dbg_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   armed_q, armed_d;
    logic                   prev_q, prev_d;
    logic                   level;
    logic                   valid;

    assign level = sync_q[SYNC_STAGES-1];
    // The chain output only reflects the real input once it has refilled after reset.
    assign valid = fill_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_i};
        fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
        armed_d = armed_q | (valid & ~level);
        prev_d  = level;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            armed_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            prev_q  <= prev_d;
        end
    end

    assign pulse_o = armed_q & level & ~prev_q;

endmodule

// File: rtl/nios2_jtag_debug_cmd_sysclk_bridge.sv
// System-clock side of the JTAG debug path: strobe sync, DR capture, channel decode,
// ack handshake, overrun flag and accepted-command counter.
module nios2_jtag_debug_cmd_sysclk_bridge
    import nios2_dbg_pkg::*;
#(
    parameter int unsigned IR_W        = 2,
    parameter int unsigned DR_W        = 38,
    parameter int unsigned ACT_BIT     = DEFAULT_ACT_BIT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned N_CH       = n_ch(IR_W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vs_uir,
    input  logic             vs_udr,
    input  logic [IR_W-1:0]  ir_in,
    input  logic [DR_W-1:0]  sr,
    input  logic             action_ack,
    input  logic             ovf_clr,
    output logic [DR_W-1:0]  jdo,
    output logic [N_CH-1:0]  take_action,
    output logic [N_CH-1:0]  take_no_action,
    output logic             cmd_pending,
    output logic [IR_W-1:0]  ir_last,
    output logic             overrun,
    output logic [CNT_W-1:0] cmd_count
);

    logic             uir_pulse;
    logic             udr_pulse;
    logic             accept;
    logic [N_CH-1:0]  ch_onehot;

    logic [DR_W-1:0]  jdo_q, jdo_d;
    logic [N_CH-1:0]  act_q, act_d;
    logic [N_CH-1:0]  noact_q, noact_d;
    logic             pending_q, pending_d;
    logic [IR_W-1:0]  ir_last_q, ir_last_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] count_q, count_d;

    nios2_dbg_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_uir_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .async_i(vs_uir),
        .pulse_o(uir_pulse)
    );

    nios2_dbg_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_udr_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .async_i(vs_udr),
        .pulse_o(udr_pulse)
    );

    // An ack in the pulse cycle frees the slot for the new command.
    assign accept    = udr_pulse & (~pending_q | action_ack);
    assign ch_onehot = {{(N_CH-1){1'b0}}, 1'b1} << ir_in;

    always_comb begin
        jdo_d     = jdo_q;
        act_d     = '0;
        noact_d   = '0;
        pending_d = pending_q;
        ir_last_d = ir_last_q;
        overrun_d = overrun_q;
        count_d   = count_q;

        if (uir_pulse) begin
            ir_last_d = ir_in;
        end

        if (accept) begin
            jdo_d     = sr;
            pending_d = 1'b1;
            count_d   = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (sr[ACT_BIT]) begin
                act_d = ch_onehot;
            end else begin
                noact_d = ch_onehot;
            end
        end else if (action_ack) begin
            pending_d = 1'b0;
        end

        if (udr_pulse && !accept) begin
            overrun_d = 1'b1;
        end else if (ovf_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo_q     <= '0;
            act_q     <= '0;
            noact_q   <= '0;
            pending_q <= 1'b0;
            ir_last_q <= '0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            jdo_q     <= jdo_d;
            act_q     <= act_d;
            noact_q   <= noact_d;
            pending_q <= pending_d;
            ir_last_q <= ir_last_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    assign jdo            = jdo_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign cmd_pending    = pending_q;
    assign ir_last        = ir_last_q;
    assign overrun        = overrun_q;
    assign cmd_count      = count_q;

endmodule

// File: tb/tb_nios2_jtag_debug_cmd_sysclk_bridge.sv
// Scoreboard bench: stimulus tasks update a transaction-level model and queue expectations;
// a negedge monitor pops and compares.
module tb_nios2_jtag_debug_cmd_sysclk_bridge;

    localparam int unsigned IR_W    = 2;
    localparam int unsigned DR_W    = 38;
    localparam int unsigned ACT_BIT = 34;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned N_CH    = 4;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic             vs_uir     = 1'b0;
    logic             vs_udr     = 1'b0;
    logic [IR_W-1:0]  ir_in      = '0;
    logic [DR_W-1:0]  sr         = '0;
    logic             action_ack = 1'b0;
    logic             ovf_clr    = 1'b0;
    logic [DR_W-1:0]  jdo;
    logic [N_CH-1:0]  take_action;
    logic [N_CH-1:0]  take_no_action;
    logic             cmd_pending;
    logic [IR_W-1:0]  ir_last;
    logic             overrun;
    logic [CNT_W-1:0] cmd_count;

    nios2_jtag_debug_cmd_sysclk_bridge #(
        .IR_W       (IR_W),
        .DR_W       (DR_W),
        .ACT_BIT    (ACT_BIT),
        .SYNC_STAGES(SYNC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .vs_uir        (vs_uir),
        .vs_udr        (vs_udr),
        .ir_in         (ir_in),
        .sr            (sr),
        .action_ack    (action_ack),
        .ovf_clr       (ovf_clr),
        .jdo           (jdo),
        .take_action   (take_action),
        .take_no_action(take_no_action),
        .cmd_pending   (cmd_pending),
        .ir_last       (ir_last),
        .overrun       (overrun),
        .cmd_count     (cmd_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              at;
        bit              act;
        int              ch;
        logic [DR_W-1:0] d;
        logic [CNT_W-1:0] cnt;
    } strobe_t;

    typedef struct {
        logic [DR_W-1:0]  d;
        logic [IR_W-1:0]  irl;
        bit               pend;
        bit               ovr;
        logic [CNT_W-1:0] cnt;
    } state_t;

    strobe_t exp_q[$];
    state_t  st_q[$];
    int      n_vec = 0;
    int      n_err = 0;

    // Transaction-level model of the architectural state.
    logic [DR_W-1:0]  m_jdo     = '0;
    logic [IR_W-1:0]  m_ir_last = '0;
    bit               m_pend    = 1'b0;
    bit               m_ovr     = 1'b0;
    logic [CNT_W-1:0] m_cnt     = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        strobe_t         e;
        state_t          s;
        logic [N_CH-1:0] oh;
        if (reset_n && (take_action != '0 || take_no_action != '0)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {take_action, take_no_action}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                oh = '0;
                oh[e.ch] = 1'b1;
                chk("strobe_cycle", cyc, e.at);
                chk("take_action", take_action, e.act ? oh : 4'b0000);
                chk("take_no_action", take_no_action, e.act ? 4'b0000 : oh);
                chk("strobe_jdo", jdo, e.d);
                chk("strobe_count", cmd_count, e.cnt);
                chk("strobe_pending", cmd_pending, 64'd1);
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
            e = exp_q.pop_front();
            chk("missing_strobe", cyc, e.at);
        end
        while (st_q.size() != 0) begin
            s = st_q.pop_front();
            chk("state_jdo", jdo, s.d);
            chk("state_ir_last", ir_last, s.irl);
            chk("state_pending", cmd_pending, s.pend);
            chk("state_overrun", overrun, s.ovr);
            chk("state_count", cmd_count, s.cnt);
            chk("state_strobes", {take_action, take_no_action}, 64'd0);
        end
    end

    function automatic logic [DR_W-1:0] rand_dr();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DR_W-1:0];
    endfunction

    task automatic push_state();
        st_q.push_back('{m_jdo, m_ir_last, m_pend, m_ovr, m_cnt});
    endtask

    // All ops start and end #1 after a rising edge.
    task automatic settle();
        push_state();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_udr(input logic [DR_W-1:0] s, input logic [IR_W-1:0] ir, input bit ack,
                          input bit with_uir);
        strobe_t e;
        sr     = s;
        ir_in  = ir;
        vs_udr = 1'b1;
        if (with_uir) begin
            vs_uir    = 1'b1;
            m_ir_last = ir;
        end
        if (!m_pend || ack) begin
            m_cnt++;
            e.at  = cyc + SYNC + 1;
            e.act = s[ACT_BIT];
            e.ch  = int'(ir);
            e.d   = s;
            e.cnt = m_cnt;
            exp_q.push_back(e);
            m_pend = 1'b1;
            m_jdo  = s;
        end else begin
            m_ovr = 1'b1;
        end
        repeat (SYNC) @(posedge clk);
        #1 action_ack = ack;
        @(posedge clk);
        #1;
        action_ack = 1'b0;
        vs_udr     = 1'b0;
        vs_uir     = 1'b0;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        settle();
    endtask

    task automatic do_ack();
        action_ack = 1'b1;
        m_pend     = 1'b0;
        @(posedge clk);
        #1 action_ack = 1'b0;
        settle();
    endtask

    task automatic do_clr();
        ovf_clr = 1'b1;
        m_ovr   = 1'b0;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        settle();
    endtask

    task automatic do_uir(input logic [IR_W-1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        repeat (SYNC) @(posedge clk);
        #1 push_state();
        @(negedge clk);
        @(posedge clk);
        #1 m_ir_last = ir;
        push_state();
        @(negedge clk);
        @(posedge clk);
        #1 vs_uir = 1'b0;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        settle();
    endtask

    initial begin : main
        int n;
        // Strobe held high across reset release must not fire.
        vs_udr = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        settle();
        vs_udr = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1;

        do_udr(38'h4_0000_1234, 2'd2, 1'b0, 1'b0);
        do_udr(rand_dr(), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        do_clr();
        do_udr(rand_dr() & ~(38'd1 << ACT_BIT), 2'd0, 1'b1, 1'b0);
        do_udr(rand_dr(), 2'd1, 1'b1, 1'b1);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0, 1: do_udr(rand_dr(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
                2: do_udr(rand_dr(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
                3: do_ack();
                4: do_clr();
                default: do_uir(2'($urandom_range(0, 3)));
            endcase
        end

        // Drive the counter through its wrap point with back-to-back acked commands.
        do_clr();
        n = (m_cnt == '0) ? 256 : 256 - int'(m_cnt);
        for (int i = 0; i < n; i++) begin
            do_udr(rand_dr(), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        do_uir(2'd3);
        do_udr(rand_dr(), 2'd1, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with a command pending.
        #2 reset_n = 1'b0;
        m_jdo     = '0;
        m_ir_last = '0;
        m_pend    = 1'b0;
        m_ovr     = 1'b0;
        m_cnt     = '0;
        push_state();
        @(negedge clk);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (SYNC + 3) @(posedge clk);
        #1;
        do_udr(rand_dr(), 2'd3, 1'b0, 1'b0);

        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
